// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory with fixed strobe length.
// Optional address range check enabled by defining ARB_ADDR_CHECK_EN.
module data_mem_arbiter #(
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned MEM_DEPTH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic        Mem_read,
  output logic        Mem_write,
  output logic [31:0] Mem_address,
  output logic [31:0] Write_data,
  input  logic [31:0] Read_Data,
  output logic        err
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $error("MEM_LAT must be in 1..15");
  end
  if (MEM_DEPTH == 0) begin : g_bad_depth
    $error("MEM_DEPTH must be non-zero");
  end

  localparam logic [3:0] LatLoad = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_b_q, last_b_d;
  logic        gnt_b_q, gnt_b_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic [31:0] b_rdata_q, b_rdata_d;

  logic        pick_b;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  // On a tie the port not granted last wins.
  assign pick_b    = b_req && (!a_req || !last_b_q);
  assign req_we    = pick_b ? b_we    : a_we;
  assign req_addr  = pick_b ? b_addr  : a_addr;
  assign req_wdata = pick_b ? b_wdata : a_wdata;

`ifdef ARB_ADDR_CHECK_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_b_d  = last_b_q;
    gnt_b_d   = gnt_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
`ifdef ARB_ADDR_CHECK_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (a_req || b_req) begin
          gnt_b_d  = pick_b;
          last_b_d = pick_b;
          we_d     = req_we;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          cnt_d    = LatLoad;
          state_d  = StAccess;
`ifdef ARB_ADDR_CHECK_EN
          err_d    = 1'b0;
          if (req_addr >= 32'(MEM_DEPTH)) begin
            state_d = StDone;
            err_d   = 1'b1;
            if (!req_we) begin
              if (pick_b) b_rdata_d = '0;
              else        a_rdata_d = '0;
            end
          end
`endif
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          if (!we_q) begin
            if (gnt_b_q) b_rdata_d = Read_Data;
            else         a_rdata_d = Read_Data;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_b_q  <= 1'b1;
      gnt_b_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
`ifdef ARB_ADDR_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_b_q  <= last_b_d;
      gnt_b_q   <= gnt_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
`ifdef ARB_ADDR_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  assign Mem_read    = (state_q == StAccess) && !we_q;
  assign Mem_write   = (state_q == StAccess) && we_q;
  assign Mem_address = (state_q == StAccess) ? addr_q : '0;
  assign Write_data  = wdata_q;
  assign a_ack       = (state_q == StDone) && !gnt_b_q;
  assign b_ack       = (state_q == StDone) && gnt_b_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;

`ifdef ARB_ADDR_CHECK_EN
  assign err = (state_q == StDone) && err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter against a transaction-timeline reference model.
module tb_data_mem_arbiter;

  localparam int unsigned MemLat   = 2;
  localparam int unsigned MemDepth = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, b_ack, Mem_read, Mem_write, err;
  logic [31:0] a_rdata, b_rdata, Mem_address, Write_data, Read_Data;

  logic        rq[2];
  logic        we_v[2];
  logic [31:0] ad_v[2];
  logic [31:0] wd_v[2];
  bit          pend[2];

  assign a_req = rq[0];  assign a_we = we_v[0];  assign a_addr = ad_v[0];  assign a_wdata = wd_v[0];
  assign b_req = rq[1];  assign b_we = we_v[1];  assign b_addr = ad_v[1];  assign b_wdata = wd_v[1];

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .MEM_LAT  (MemLat),
    .MEM_DEPTH(MemDepth)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .a_req      (a_req),
    .a_we       (a_we),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_ack      (a_ack),
    .a_rdata    (a_rdata),
    .b_req      (b_req),
    .b_we       (b_we),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_ack      (b_ack),
    .b_rdata    (b_rdata),
    .Mem_read   (Mem_read),
    .Mem_write  (Mem_write),
    .Mem_address(Mem_address),
    .Write_data (Write_data),
    .Read_Data  (Read_Data),
    .err        (err)
  );

  // Memory outside the DUT, plus the model's own copy of what memory should hold.
  logic [31:0] env_mem[16];
  logic [31:0] mmem[16];

  function automatic logic [31:0] oor_pat(input logic [31:0] a);
    return 32'hA5A5_0000 ^ a;
  endfunction

  assign Read_Data = (Mem_address < MemDepth) ? env_mem[Mem_address[3:0]] : oor_pat(Mem_address);

  function automatic logic [31:0] mem_value(input logic [31:0] a);
    return (a < MemDepth) ? mmem[a[3:0]] : oor_pat(a);
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, described by its grant edge and length.
  int          e = 0;
  int          g_e = 0;
  int          port = 0;
  int          done_j = 0;
  bit          busy = 0;
  bit          last_b = 1;
  bit          m_we = 0;
  bit          oor = 0;
  logic [31:0] m_addr, m_wdata, rd_val;
  logic [31:0] exp_rd[2] = '{32'h0, 32'h0};

  task automatic model_edge();
    e++;
    if (reset) begin
      busy = 0;
      last_b = 1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      return;
    end
    if (busy && (e - g_e == done_j + 1)) begin
      busy = 0;
    end else if (!busy && (rq[0] || rq[1])) begin
      port    = (rq[0] && rq[1]) ? (last_b ? 0 : 1) : (rq[0] ? 0 : 1);
      last_b  = (port == 1);
      busy    = 1;
      g_e     = e;
      m_we    = we_v[port];
      m_addr  = ad_v[port];
      m_wdata = wd_v[port];
`ifdef ARB_ADDR_CHECK_EN
      oor     = (m_addr >= MemDepth);
`else
      oor     = 0;
`endif
      done_j  = oor ? 0 : int'(MemLat);
      rd_val  = oor ? 32'h0 : mem_value(m_addr);
      if (!oor && m_we && m_addr < MemDepth) mmem[m_addr[3:0]] = m_wdata;
    end
    if (busy && (e - g_e == done_j) && !m_we) exp_rd[port] = rd_val;
  endtask

  task automatic check_outputs();
    bit in_acc, in_done;
    in_acc  = busy && (e - g_e < done_j);
    in_done = busy && (e - g_e == done_j);
    check_eq("mem_read", Mem_read, in_acc && !m_we);
    check_eq("mem_write", Mem_write, in_acc && m_we);
    check_eq("mem_address", Mem_address, in_acc ? m_addr : 32'h0);
    if (in_acc && m_we) check_eq("write_data", Write_data, m_wdata);
    check_eq("a_ack", a_ack, in_done && port == 0);
    check_eq("b_ack", b_ack, in_done && port == 1);
    check_eq("err", err, in_done && oor);
    check_eq("a_rdata", a_rdata, exp_rd[0]);
    check_eq("b_rdata", b_rdata, exp_rd[1]);
  endtask

  // Called at a negedge; advances one clock and checks the new cycle.
  task automatic tick();
    logic        wr;
    logic [31:0] wa, wd;
    wr = Mem_write;
    wa = Mem_address;
    wd = Write_data;
    @(posedge clk);
    if (wr === 1'b1 && wa < MemDepth) env_mem[wa[3:0]] = wd;
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rand_fields(input int p);
    we_v[p] = 1'($urandom % 2);
    ad_v[p] = ($urandom % 8 == 0) ? 32'(MemDepth + $urandom % 10) : 32'($urandom % MemDepth);
    wd_v[p] = $urandom;
  endtask

  task automatic drive_random();
    bit mine, dn;
    for (int p = 0; p < 2; p++) begin
      mine = busy && port == p;
      dn   = mine && (e - g_e == done_j);
      if (dn) begin
        pend[p] = 0;
        if ($urandom % 2 == 1) begin
          pend[p] = 1;
          rq[p]   = 1;
          rand_fields(p);
        end else begin
          rq[p] = 0;
        end
      end else if (mine) begin
        // Requester scribbles on its fields after grant; sometimes drops req too.
        rand_fields(p);
        if ($urandom % 4 == 0) rq[p] = 0;
      end else if (!pend[p]) begin
        if ($urandom % 3 == 0) begin
          pend[p] = 1;
          rq[p]   = 1;
          rand_fields(p);
        end
      end
    end
  endtask

  task automatic do_txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat);
    bit seen;
    we_v[p] = w;
    ad_v[p] = a;
    wd_v[p] = d;
    rq[p]   = 1;
    lat     = 0;
    seen    = 0;
    while (!seen && lat < 30) begin
      tick();
      lat++;
      seen = (p == 0) ? a_ack : b_ack;
    end
    rq[p] = 0;
    check_eq("ack_seen", 32'(seen), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, exp_p, got_p, acks, guard;
    for (int i = 0; i < 16; i++) begin
      env_mem[i] = $urandom;
      mmem[i]    = env_mem[i];
    end
    for (int p = 0; p < 2; p++) begin
      rq[p] = 0; we_v[p] = 0; ad_v[p] = '0; wd_v[p] = '0; pend[p] = 0;
    end

    // Reset state
    reset = 1;
    @(negedge clk);
    tick();
    tick();
    check_eq("rst_write_data", Write_data, 32'h0);
    reset = 0;
    tick();

    // Simple read with known contents
    env_mem[3] = 32'd5;
    mmem[3]    = 32'd5;
    do_txn(0, 1'b0, 32'd3, 32'h0, lat);
    check_eq("read3_latency", lat, MemLat + 1);
    check_eq("read3_rdata", a_rdata, 32'd5);
    tick();

    // Write through B, read back through A
    do_txn(1, 1'b1, 32'd7, 32'h55, lat);
    check_eq("write7_latency", lat, MemLat + 1);
    tick();
    do_txn(0, 1'b0, 32'd7, 32'h0, lat);
    check_eq("readback7", a_rdata, 32'h55);
    tick();

    // Both held high: grants must alternate
    we_v[0] = 0; ad_v[0] = 32'd1;
    we_v[1] = 0; ad_v[1] = 32'd2;
    rq[0] = 1; rq[1] = 1;
    exp_p = last_b ? 0 : 1;
    acks  = 0;
    guard = 0;
    while (acks < 4 && guard < 60) begin
      tick();
      guard++;
      if (a_ack || b_ack) begin
        got_p = (a_ack && b_ack) ? 2 : (a_ack ? 0 : 1);
        check_eq("rr_order", got_p, exp_p);
        exp_p ^= 1;
        acks++;
      end
    end
    rq[0] = 0; rq[1] = 0;
    check_eq("rr_ack_count", acks, 4);
    tick();

    // Out-of-range address
    do_txn(0, 1'b0, 32'd12, 32'h0, lat);
`ifdef ARB_ADDR_CHECK_EN
    check_eq("oor_latency", lat, 1);
    check_eq("oor_rdata", a_rdata, 32'h0);
`else
    check_eq("oor_latency", lat, MemLat + 1);
    check_eq("oor_rdata", a_rdata, oor_pat(32'd12));
`endif
    tick();

    // Randomized traffic from both ports
    for (int i = 0; i < 1500; i++) begin
      tick();
      drive_random();
    end
    rq[0] = 0; rq[1] = 0;
    guard = 0;
    while (busy && guard < 20) begin
      tick();
      guard++;
    end
    check_eq("drain_idle", busy, 0);
    tick();

    // Reset in the first ACCESS cycle of a write by A
    we_v[0] = 1; ad_v[0] = 32'd4; wd_v[0] = $urandom;
    rq[0] = 1;
    tick();
    check_eq("pre_rst_write", Mem_write, 1);
    rq[0] = 0;
    reset = 1;
    tick();
    check_eq("rst_abort_write", Mem_write, 0);
    reset = 0;
    tick();
    tick();
    // Last-grant flag is back to B, so A wins this tie
    we_v[0] = 0; ad_v[0] = 32'd5;
    we_v[1] = 0; ad_v[1] = 32'd6;
    rq[0] = 1; rq[1] = 1;
    guard = 0;
    got_p = 3;
    while (got_p == 3 && guard < 20) begin
      tick();
      guard++;
      if (a_ack || b_ack) got_p = (a_ack && b_ack) ? 2 : (a_ack ? 0 : 1);
    end
    rq[0] = 0; rq[1] = 0;
    check_eq("tie_after_reset", got_p, 0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clk and reset.
REQ-002 Parameter MEM_LAT, default 2: number of cycles Mem_read/Mem_write are held per access, legal range 1..15.
REQ-003 Parameter MEM_DEPTH, default 10: number of 32-bit words in the data memory.
REQ-004 clk  input  1  clock; all state changes on posedge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 a_req  input  1  port A (pipeline MEM stage) request, held until a_ack.
REQ-007 a_we  input  1  port A: 1 = write, 0 = read.
REQ-008 a_addr  input  32  port A word address.
REQ-009 a_wdata  input  32  port A write data.
REQ-010 a_ack  output  1  port A one-cycle completion pulse.
REQ-011 a_rdata  output  32  port A read data.
REQ-012 b_req, b_we, b_addr, b_wdata, b_ack, b_rdata SHALL mirror the port A signals in direction and width, and serve port B (loader/debug).
REQ-013 Mem_read  output  1  read strobe to the data memory.
REQ-014 Mem_write  output  1  write strobe to the data memory.
REQ-015 Mem_address  output  32  address to the data memory.
REQ-016 Write_data  output  32  write data to the data memory.
REQ-017 Read_Data  input  32  read data from the data memory.
REQ-018 err  output  1  error pulse issued with ack (see Configuration).

Function
REQ-019 FSM states: IDLE, ACCESS, DONE; reset state is IDLE.
REQ-020 IDLE: if any req=1 at a posedge, grant one port, latch its we/addr/wdata, and go to ACCESS; otherwise stay in IDLE.
REQ-021 Tie (a_req=b_req=1 in IDLE): grant the port not granted last (round-robin); the last-grant flag resets to B, so A wins the first tie.
REQ-022 ACCESS: drive the latched address and data; assert Mem_read (read) or Mem_write (write) for exactly MEM_LAT cycles, timed by a down-counter; then go to DONE.
REQ-023 Read_Data SHALL be captured into the granted port's rdata on the last ACCESS cycle; rdata holds until that port's next read completes.
REQ-024 DONE: pulse the granted port's ack for exactly one cycle, then return to IDLE.
REQ-025 Latency: grant edge k gives ack high in cycle k+MEM_LAT+1; the next grant is possible no earlier than edge k+MEM_LAT+2.
REQ-026 Mem_read, Mem_write and Mem_address SHALL be 0 outside ACCESS; Mem_read and Mem_write SHALL never be 1 together.
REQ-027 Latched request fields are immune to requester changes after grant; a req dropped mid-access still completes and still acks.
REQ-028 If req is still high in the IDLE cycle after its ack, it is a new request.
REQ-029 The ungranted port's ack SHALL stay 0, its rdata unchanged.

Reset
REQ-030 On reset: state=IDLE, counter=0, last-grant=B, a_ack=b_ack=err=0, Mem_read=Mem_write=0, Mem_address=Write_data=0, a_rdata=b_rdata=0.
REQ-031 Reset during ACCESS SHALL abort the access: strobes low from the next cycle, no ack issued.

Configuration
REQ-032 Macro ARB_ADDR_CHECK_EN defined: a granted request with addr >= MEM_DEPTH SHALL skip ACCESS, go directly to DONE, pulse ack together with err, and set that port's rdata to 0 on reads; no memory strobe is asserted.
REQ-033 Macro ARB_ADDR_CHECK_EN undefined: no range check is performed, all addresses go to memory, and err SHALL be tied to 0.

Verification
REQ-034 Reset, then a_req read addr 3 with memory[3]=5, MEM_LAT=2 -> Mem_read high 2 cycles with Mem_address=3, a_ack pulses 3 cycles after grant, a_rdata=5.
REQ-035 a_req and b_req both held high, each re-requesting after ack -> grants alternate A,B,A,B; Mem_read and Mem_write never both high.
REQ-036 b_req write addr 7 data 0x55, then a_req read addr 7 -> Mem_write high 2 cycles with Write_data=0x55, then a_rdata=0x55.
REQ-037 Reset asserted in the 1st ACCESS cycle of a write -> Mem_write low next cycle, no ack, state IDLE, last-grant=B.
REQ-038 With ARB_ADDR_CHECK_EN, a_req read addr 12 -> no strobes, a_ack and err pulse together 1 cycle after grant, a_rdata=0; without the macro, Mem_read asserts with Mem_address=12 and err stays 0.
